// File: rtl/uart_fifo_top.sv
// uart_fifo_top: register-mapped UART with TX and RX FIFOs.
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_we, i_re        : register write / read strobes (read pops RX on DATA)
//   i_address, i_data : register select and write data
//   o_data            : combinational read data (0 for unmapped addresses)
//   i_rx, o_tx        : serial in (synchronised) / serial out (registered, idle high)
//   o_irq             : registered interrupt
// Registers: 0x00 STATUS, 0x01 CTRL, 0x02 DIVL, 0x03 DIVH, 0x04 DATA.

// uart_fifo_buf: synchronous FIFO with occupancy count.
//   push/pop are qualified internally; a push into a full FIFO is accepted
//   only when a pop happens on the same edge.
module uart_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          rd_ok, wr_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_ok = pop & ~empty;
    assign wr_ok = push & (~full | rd_ok);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_fifo_top #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_we,
    input  logic       i_re,
    input  logic [7:0] i_address,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_irq
);
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [3:0]       ctrl;
    logic [DIV_W-1:0] div, presc;
    logic             tick, overrun, frame_err;
    logic             wr_status, wr_ctrl, wr_divl, wr_divh, wr_data, rx_pop;

    logic              tx_empty, tx_full, tx_pop, tx_bit_end, tx_line_n, tx_idle;
    logic [DATA_W-1:0] tx_head, tx_shift, tx_shift_n;
    logic [3:0]        tx_cnt, tx_cnt_n, tx_bit, tx_bit_n;
    tx_state_t         tx_state, tx_state_n;

    logic              rx_meta, rx_s, rx_prev, rx_fall;
    logic              rx_empty, rx_full, rx_push, rx_set_ovr, rx_set_fe;
    logic [DATA_W-1:0] rx_head, rx_shift, rx_shift_n;
    logic [3:0]        rx_cnt, rx_cnt_n, rx_bit, rx_bit_n;
    rx_state_t         rx_state, rx_state_n;

    logic [7:0] divh_rd, rx_head_ext;

    assign wr_status = i_we && (i_address == 8'h00);
    assign wr_ctrl   = i_we && (i_address == 8'h01);
    assign wr_divl   = i_we && (i_address == 8'h02);
    assign wr_divh   = i_we && (i_address == 8'h03);
    assign wr_data   = i_we && (i_address == 8'h04);
    assign rx_pop    = i_re && (i_address == 8'h04) && !rx_empty;
    assign tick      = (presc == div);
    assign tx_idle   = tx_empty && (tx_state == TX_IDLE);

    uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (wr_data && !tx_full),
        .pop   (tx_pop),
        .wdata (i_data[DATA_W-1:0]),
        .rdata (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    uart_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (rx_shift_n),
        .rdata (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // Registers, prescaler, sticky flags, interrupt, RX synchroniser
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl      <= '0;
            div       <= '0;
            presc     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            o_irq     <= 1'b0;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
        end else begin
            if (wr_ctrl) ctrl <= i_data[3:0];
            if (wr_divl) div[7:0] <= i_data;
            if (wr_divh) div[DIV_W-1:8] <= i_data[DIV_W-9:0];
            if (wr_divl || wr_divh || tick) presc <= '0;
            else                            presc <= presc + DIV_W'(1);
            overrun   <= rx_set_ovr | (overrun   & ~(wr_status & i_data[3]));
            frame_err <= rx_set_fe  | (frame_err & ~(wr_status & i_data[4]));
            o_irq     <= (ctrl[2] & ~rx_empty) | (ctrl[3] & tx_idle);
            rx_meta   <= i_rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
        end
    end

    assign rx_fall = rx_prev & ~rx_s;

    // TX FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            o_tx     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            o_tx     <= tx_line_n;
        end
    end

    assign tx_bit_end = tick && (tx_cnt == 4'd15);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        tx_line_n  = 1'b1;
        // Tick counter wraps 15 -> 0, so each bit boundary restarts it for free.
        if (tx_state != TX_IDLE && tick) tx_cnt_n = tx_cnt + 4'd1;
        case (tx_state)
            TX_IDLE: if (ctrl[0] && !tx_empty) begin
                tx_state_n = TX_START;
                tx_cnt_n   = '0;
                tx_shift_n = tx_head;
                tx_pop     = 1'b1;
            end
            TX_START: if (tx_bit_end) begin
                tx_state_n = TX_DATA;
                tx_bit_n   = '0;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_shift_n = tx_shift >> 1;
                if (tx_bit == 4'(DATA_W-1)) tx_state_n = TX_STOP;
                else                        tx_bit_n   = tx_bit + 4'd1;
            end
            TX_STOP: if (tx_bit_end) begin
                if (ctrl[0] && !tx_empty) begin
                    tx_state_n = TX_START;
                    tx_shift_n = tx_head;
                    tx_pop     = 1'b1;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        case (tx_state_n)
            TX_START: tx_line_n = 1'b0;
            TX_DATA:  tx_line_n = tx_shift_n[0];
            default:  tx_line_n = 1'b1;
        endcase
    end

    // RX FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        rx_set_ovr = 1'b0;
        rx_set_fe  = 1'b0;
        if (rx_state != RX_IDLE && tick) rx_cnt_n = rx_cnt + 4'd1;
        case (rx_state)
            RX_IDLE: if (rx_fall) begin
                rx_state_n = RX_START;
                rx_cnt_n   = '0;
            end
            RX_START: if (tick && rx_cnt == 4'd7) begin
                // Mid start bit: restart the count so later samples land mid-bit.
                rx_cnt_n = '0;
                rx_bit_n = '0;
                rx_state_n = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick && rx_cnt == 4'd15) begin
                rx_shift_n = {rx_s, rx_shift[DATA_W-1:1]};
                if (rx_bit == 4'(DATA_W-1)) rx_state_n = RX_STOP;
                else                        rx_bit_n   = rx_bit + 4'd1;
            end
            RX_STOP: if (tick && rx_cnt == 4'd15) begin
                rx_state_n = RX_IDLE;
                if (!rx_s)                  rx_set_fe  = 1'b1;
                else if (rx_full && !rx_pop) rx_set_ovr = 1'b1;
                else                        rx_push    = 1'b1;
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (!ctrl[1]) begin
            rx_state_n = RX_IDLE;
            rx_push    = 1'b0;
            rx_set_ovr = 1'b0;
            rx_set_fe  = 1'b0;
        end
    end

    // Read mux
    always_comb begin
        divh_rd = '0;
        divh_rd[DIV_W-9:0] = div[DIV_W-1:8];
        rx_head_ext = '0;
        if (!rx_empty) rx_head_ext[DATA_W-1:0] = rx_head;
    end

    always_comb begin
        o_data = '0;
        case (i_address)
            8'h00:   o_data = {3'b000, frame_err, overrun, tx_idle, tx_full, ~rx_empty};
            8'h01:   o_data = {4'b0000, ctrl};
            8'h02:   o_data = div[7:0];
            8'h03:   o_data = divh_rd;
            8'h04:   o_data = rx_head_ext;
            default: o_data = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_top.sv
// tb_uart_fifo_top: self-checking bench for uart_fifo_top (default parameters,
// DIV=0 so one bit = 16 clocks unless stated otherwise).
module tb_uart_fifo_top;
    logic       clk = 1'b0;
    logic       rst, we, re, rx_drv, loop;
    logic [7:0] addr, wdata;
    logic [7:0] o_data;
    logic       o_tx, o_irq, rx_line;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames = 0;
    int starts[$];
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       mon_en, mon_cap;
    logic [7:0] mon_b;

    assign rx_line = loop ? o_tx : rx_drv;

    uart_fifo_top #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (we),
        .i_re      (re),
        .i_address (addr),
        .i_data    (wdata),
        .o_data    (o_data),
        .i_rx      (rx_line),
        .o_tx      (o_tx),
        .o_irq     (o_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic pop, output logic [7:0] d);
        @(negedge clk);
        addr = a; re = pop;
        #1 d = o_data;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = stop;
        repeat (16) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Serial TX monitor: decodes frames mid-bit and checks them against txq.
    initial begin
        forever begin
            @(negedge o_tx);
            if (!rst) begin
                mon_cap = mon_en;
                starts.push_back(cyc);
                repeat (8) @(negedge clk);
                if (mon_cap) check_eq("tx_start_bit", o_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    mon_b[i] = o_tx;
                end
                repeat (16) @(negedge clk);
                if (mon_cap && mon_en) begin
                    check_eq("tx_stop_bit", o_tx, 1);
                    if (txq.size() == 0) check_eq("tx_frame_expected", txq.size(), 1);
                    else check_eq("tx_frame_data", mon_b, txq.pop_front());
                    frames++;
                end
            end
        end
    end

    initial begin
        logic [7:0] d, b;
        int n, nf, ns;
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
        rx_drv = 1'b1; loop = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h00, 1'b0, d); check_eq("rst_status", d, 8'h04);
        rd(8'h01, 1'b0, d); check_eq("rst_ctrl", d, 8'h00);
        check_eq("rst_tx", o_tx, 1);
        check_eq("rst_irq", o_irq, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        rd(8'h02, 1'b0, d); check_eq("rst_divl", d, 8'h00);
        rd(8'h03, 1'b0, d); check_eq("rst_divh", d, 8'h00);

        // Register access
        wr(8'h01, 8'hFF); rd(8'h01, 1'b0, d); check_eq("ctrl_rw", d, 8'h0F);
        wr(8'h01, 8'h00);
        wr(8'h03, 8'hA5); rd(8'h03, 1'b0, d); check_eq("divh_rw", d, 8'hA5);
        wr(8'h03, 8'h00);
        rd(8'h05, 1'b0, d); check_eq("unmapped_rd", d, 8'h00);

        // Single TX frame 0xA5
        wr(8'h01, 8'h01);
        txq.push_back(8'hA5);
        wr(8'h04, 8'hA5);
        addr = 8'h00;
        check_eq("tx_busy", o_data[2], 0);
        n = 0;
        while (o_data[2] == 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("tx_idle_after_frame", (n >= 159 && n <= 163), 1);
        repeat (10) @(negedge clk);

        // TX FIFO fill with TX disabled
        wr(8'h01, 8'h00);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (i < 4) txq.push_back(b);
            wr(8'h04, b);
            rd(8'h00, 1'b0, d);
            check_eq("tx_full", d[1], (i >= 3));
        end
        nf = frames;
        wr(8'h01, 8'h01);
        repeat (4 * 161 + 20) @(negedge clk);
        check_eq("tx_frame_count", frames - nf, 4);
        check_eq("txq_drained", txq.size(), 0);

        // Loopback, back-to-back frames
        loop = 1'b1;
        wr(8'h01, 8'h07);
        ns = starts.size();
        txq.push_back(8'h3C); rxq.push_back(8'h3C);
        txq.push_back(8'hC3); rxq.push_back(8'hC3);
        wr(8'h04, 8'h3C);
        wr(8'h04, 8'hC3);
        repeat (360) @(negedge clk);
        if (starts.size() >= ns + 2) check_eq("b2b_gap", starts[ns+1] - starts[ns], 160);
        else check_eq("b2b_frames", starts.size() - ns, 2);
        check_eq("irq_rx", o_irq, 1);
        rd(8'h00, 1'b0, d); check_eq("rx_not_empty", d[0], 1);
        rd(8'h04, 1'b1, d); check_eq("loop_rx0", d, rxq.pop_front());
        rd(8'h04, 1'b1, d); check_eq("loop_rx1", d, rxq.pop_front());
        rd(8'h00, 1'b0, d); check_eq("rx_empty_after", d[0], 0);
        repeat (2) @(negedge clk);
        check_eq("irq_cleared", o_irq, 0);
        wr(8'h01, 8'h00);
        loop = 1'b0;

        // RX overrun: 5 frames, no reads
        wr(8'h01, 8'h02);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (i < 4) rxq.push_back(b);
            send_frame(b, 1'b1);
        end
        rd(8'h00, 1'b0, d); check_eq("overrun_status", d, 8'h0D);
        for (int i = 0; i < 4; i++) begin
            rd(8'h04, 1'b1, d); check_eq("ovr_rx_data", d, rxq.pop_front());
        end
        rd(8'h04, 1'b1, d); check_eq("rx_empty_read", d, 8'h00);
        wr(8'h00, 8'h08);
        rd(8'h00, 1'b0, d); check_eq("overrun_w1c", d, 8'h04);

        // Framing error, glitch, then a good frame
        send_frame(8'h5A, 1'b0);
        rd(8'h00, 1'b0, d); check_eq("frame_err", d, 8'h14);
        wr(8'h00, 8'h10);
        rd(8'h00, 1'b0, d); check_eq("frame_err_w1c", d, 8'h04);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        rd(8'h00, 1'b0, d); check_eq("glitch_ignored", d, 8'h04);
        rxq.push_back(8'h96);
        send_frame(8'h96, 1'b1);
        rd(8'h04, 1'b1, d); check_eq("rx_after_glitch", d, rxq.pop_front());
        rd(8'h00, 1'b0, d); check_eq("status_idle", d, 8'h04);
        wr(8'h01, 8'h00);

        // TX-idle interrupt
        wr(8'h01, 8'h08);
        @(negedge clk);
        check_eq("irq_tx_idle", o_irq, 1);
        wr(8'h01, 8'h00);
        repeat (2) @(negedge clk);
        check_eq("irq_tx_off", o_irq, 0);

        // DIV=1 doubles the frame time
        mon_en = 1'b0;
        wr(8'h02, 8'h01);
        wr(8'h01, 8'h01);
        wr(8'h04, 8'hFF);
        addr = 8'h00;
        n = 0;
        while (o_data[2] == 1'b0 && n < 800) begin
            @(negedge clk);
            n++;
        end
        check_eq("div1_frame_len", (n >= 316 && n <= 324), 1);
        wr(8'h02, 8'h00);
        wr(8'h01, 8'h00);
        mon_en = 1'b1;

        // Reset in the middle of a TX frame
        wr(8'h01, 8'h01);
        mon_en = 1'b0;
        wr(8'h04, 8'h00);
        repeat (40) @(negedge clk);
        check_eq("tx_mid_frame_low", o_tx, 0);
        #2 rst = 1'b1;
        #1 check_eq("tx_async_reset", o_tx, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(8'h00, 1'b0, d); check_eq("post_rst_status", d, 8'h04);
        rd(8'h01, 1'b0, d); check_eq("post_rst_ctrl", d, 8'h00);
        repeat (200) @(negedge clk);
        check_eq("post_rst_tx_idle", o_tx, 1);
        mon_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_fifo_top.md
UART_FIFO_TOP -- requirements
Module: uart_fifo_top

Parameters
REQ-001 DATA_W, 8, character length in bits; legal range 5..8.
REQ-002 FIFO_DEPTH, 4, entries per TX FIFO and per RX FIFO; power of two, at least 2.
REQ-003 DIV_W, 16, baud divisor width; legal range 9..16.

Interface
REQ-004 i_clk  input  1  system clock; all state updates on the rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_we  input  1  register write strobe; one write per cycle while high.
REQ-007 i_re  input  1  register read strobe; read side effects (RX pop) occur only while high.
REQ-008 i_address  input  8  register select.
REQ-009 i_data  input  8  write data.
REQ-010 o_data  output  8  read data, combinational from i_address; 0 for unmapped addresses.
REQ-011 i_rx  input  1  serial input, idle high; passes through a two-flop synchroniser (reset value 1) before use.
REQ-012 o_tx  output  1  serial output, registered, idle high.
REQ-013 o_irq  output  1  interrupt, registered.

Function
REQ-014 Register 0x00 STATUS: bit0 rx_not_empty, bit1 tx_full, bit2 tx_idle (TX FIFO empty and TX FSM in IDLE), bit3 overrun (sticky), bit4 frame_err (sticky), bits7:5 zero; a write with bit3 or bit4 set clears that flag (write-1-to-clear), other bits ignored.
REQ-015 Register 0x01 CTRL (RW): bit0 tx_en, bit1 rx_en, bit2 irq_rx_en, bit3 irq_tx_en; bits7:4 read zero.
REQ-016 Registers 0x02 DIVL and 0x03 DIVH (RW) form DIV[DIV_W-1:0]; unimplemented DIVH bits read zero; a write to either register resets the prescaler to 0.
REQ-017 Register 0x04 DATA: a write pushes i_data[DATA_W-1:0] into the TX FIFO; a read shows the RX FIFO head zero-extended to 8 bits (0 when empty); a read with i_re high pops that entry on the same clock edge.
REQ-018 Writes to addresses 0x05..0xFF are ignored.
REQ-019 Prescaler: counts every cycle and emits a one-cycle tick when count equals DIV, then reloads 0; DIV=0 produces a tick every cycle; one bit time is 16 ticks.
REQ-020 TX FSM states: IDLE, START, DATA, STOP; each bit lasts 16 ticks; LSB first; DATA_W data bits; one stop bit.
REQ-021 TX leaves IDLE for START when tx_en=1 and the TX FIFO is not empty, popping the FIFO head into the shifter on that edge.
REQ-022 TX goes from STOP directly to START (no idle gap) when tx_en=1 and the FIFO is not empty, otherwise to IDLE.
REQ-023 Clearing tx_en mid-frame lets the current frame complete; no further pop follows.
REQ-024 A DATA write while the TX FIFO is full is dropped with no state change.
REQ-025 RX FSM states: IDLE, START, DATA, STOP; a synchronised falling edge in IDLE with rx_en=1 enters START.
REQ-026 START samples at tick 8; if the line is high, it is a false start and the FSM returns to IDLE with nothing pushed.
REQ-027 DATA samples at the middle of each bit (every 16 ticks after the start-bit sample), LSB first.
REQ-028 STOP sample 0: set frame_err, discard the character, return to IDLE.
REQ-029 STOP sample 1 with the RX FIFO full and no pop in the same cycle: set overrun and discard; FIFO contents are unchanged.
REQ-030 STOP sample 1 with the RX FIFO full and a pop in the same cycle: push accepted, no overrun.
REQ-031 A pop from an empty RX FIFO has no effect.
REQ-032 FIFO pointers wrap modulo FIFO_DEPTH; full/empty come from an occupancy count of width log2(FIFO_DEPTH)+1.
REQ-033 o_irq is registered from (irq_rx_en AND rx_not_empty) OR (irq_tx_en AND tx_idle) with one-cycle latency.
REQ-034 Clearing rx_en mid-frame aborts RX to IDLE without a push.

Reset
REQ-035 While i_rst=1: both FIFOs empty; CTRL=0x00; DIV=0; prescaler=0; sticky flags=0; both FSMs in IDLE; o_tx=1; o_irq=0; STATUS reads 0x04.
REQ-036 Reset asserted mid-frame forces o_tx=1 immediately (asynchronously) and discards any partial RX character.

Verification
REQ-037 TX: DIV=0, CTRL=0x01, write DATA=0xA5 -> o_tx shows start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 16 cycles; STATUS bit2 returns to 1 after 160 cycles.
REQ-038 Loopback (o_tx to i_rx), CTRL=0x07, write 0x3C, 0xC3 -> frames are back-to-back; o_irq rises; DATA reads 0x3C then 0xC3 (with i_re); STATUS bit0 then 0.
REQ-039 FIFO_DEPTH=4, TX disabled: write 5 bytes -> tx_full after the 4th, 5th dropped; enabling TX sends exactly 4 frames.
REQ-040 RX overrun: receive 5 frames without reading -> STATUS bit3=1, DATA yields the first 4 bytes in order; writing 0x08 to 0x00 clears bit3.
REQ-041 Framing: drive a frame with stop bit 0 -> frame_err=1, no push; a 4-tick low glitch on i_rx -> no state change.
REQ-042 Assert i_rst mid-TX frame -> o_tx=1 immediately; STATUS=0x04 and CTRL=0x00 after release.
